// File: rtl/serial2parallel_pkg.sv
// Shared FFT32 width constants and gather-stage types.
package serial2parallel_pkg;

  localparam int FFT_NB     = 16;
  localparam int FFT_LEN    = 32;
  localparam int FFT_LANES  = 4;
  localparam int FFT_GROUPS = FFT_LEN / FFT_LANES;

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_COLLECT = 1'b1
  } s2p_state_e;

endpackage

// File: rtl/serial2parallel_if.sv
// Serial sample input and gathered parallel word output of the FFT32 gather stage.
interface serial2parallel_if #(
  parameter int NB = serial2parallel_pkg::FFT_NB
);
  logic            START;
  logic            IVLD;
  logic [NB-1:0]   IR;
  logic [NB-1:0]   II;
  logic [4*NB-1:0] DR;
  logic [4*NB-1:0] DI;
  logic            RDY;
  logic            LAST;
  logic            BUSY;

  modport master (output START, IVLD, IR, II,
                  input  DR, DI, RDY, LAST, BUSY);

  modport slave  (input  START, IVLD, IR, II,
                  output DR, DI, RDY, LAST, BUSY);
endinterface

// File: rtl/serial2parallel_lane_gather.sv
// 4-lane write-by-index assembly register with a commit-to-output word.
// Lane 0 is the MSB lane of the output word; the committing sample
// bypasses straight into the LSB lane.
module serial2parallel_lane_gather #(
  parameter int NB = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic [1:0]      wr_idx,
  input  logic [NB-1:0]   wr_data,
  input  logic            commit,
  output logic [4*NB-1:0] dout
);

  logic [NB-1:0]   lane_q [4];
  logic [NB-1:0]   lane_d [4];
  logic [4*NB-1:0] dout_q;
  logic [4*NB-1:0] dout_d;

  // Lane write and output commit; dout holds until the next commit.
  always_comb begin
    lane_d = lane_q;
    dout_d = dout_q;
    if (wr_en) begin
      lane_d[wr_idx] = wr_data;
    end
    if (commit) begin
      dout_d = {lane_q[0], lane_q[1], lane_q[2], wr_data};
    end
  end

  // Assembly lanes and output word registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 4; i++) begin
        lane_q[i] <= '0;
      end
      dout_q <= '0;
    end else begin
      lane_q <= lane_d;
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/serial2parallel.sv
// FFT32 input gather: serial complex samples into 4-lane words with RDY/LAST.
module serial2parallel
  import serial2parallel_pkg::*;
#(
  parameter int NB     = FFT_NB,
  parameter int GROUPS = FFT_GROUPS
) (
  input  logic              CLK,
  input  logic              RST,
  serial2parallel_if.slave  bus
);

  localparam int GW = (GROUPS > 1) ? $clog2(GROUPS) : 1;

  s2p_state_e      state_q, state_d;
  logic [1:0]      lane_q, lane_d;
  logic [GW-1:0]   group_q, group_d;
  logic            rdy_q, rdy_d;
  logic            last_q, last_d;
  logic            wr_en;
  logic [1:0]      wr_idx;
  logic            commit;
  logic [4*NB-1:0] dr_w;
  logic [4*NB-1:0] di_w;

  // Next-state: START always restarts at lane 0 of group 0, discarding any
  // partial group; in COLLECT a valid sample fills the next lane and the
  // fourth lane commits the word.
  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    group_d = group_q;
    rdy_d   = 1'b0;
    last_d  = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = lane_q;
    commit  = 1'b0;
    if (bus.START) begin
      wr_en   = 1'b1;
      wr_idx  = 2'd0;
      lane_d  = 2'd1;
      group_d = '0;
      state_d = S_COLLECT;
    end else if (bus.IVLD && (state_q == S_COLLECT)) begin
      wr_en  = 1'b1;
      lane_d = lane_q + 2'd1;
      if (lane_q == 2'd3) begin
        commit = 1'b1;
        rdy_d  = 1'b1;
        if (group_q == GW'(GROUPS - 1)) begin
          last_d  = 1'b1;
          group_d = '0;
          state_d = S_IDLE;
        end else begin
          group_d = group_q + GW'(1);
        end
      end
    end
  end

  // Control state registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      lane_q  <= '0;
      group_q <= '0;
      rdy_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      group_q <= group_d;
      rdy_q   <= rdy_d;
      last_q  <= last_d;
    end
  end

  serial2parallel_lane_gather #(.NB(NB)) u_gather_re (
    .clk     (CLK),
    .rst_n   (RST),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_data (bus.IR),
    .commit  (commit),
    .dout    (dr_w)
  );

  serial2parallel_lane_gather #(.NB(NB)) u_gather_im (
    .clk     (CLK),
    .rst_n   (RST),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_data (bus.II),
    .commit  (commit),
    .dout    (di_w)
  );

  assign bus.DR   = dr_w;
  assign bus.DI   = di_w;
  assign bus.RDY  = rdy_q;
  assign bus.LAST = last_q;
  assign bus.BUSY = (state_q == S_COLLECT);

endmodule
